// File: rtl/scratchpad_feature_pingpong.sv
// Double-buffered feature scratchpad: one bank fills by random or sliding-window
// writes while the other, committed bank is presented to the PE array.
module scratchpad_feature_pingpong #(
  parameter int unsigned TN            = 4,
  parameter int unsigned KERNEL_SIZE   = 5,
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned GROUP_AW      = 9,
  parameter int unsigned LINE_AW       = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_valid,
  output logic                                      wr_ready,
  input  logic [GROUP_AW-1:0]                       wr_mem_group,
  input  logic [LINE_AW-1:0]                        wr_mem_line,
  input  logic                                      wr_shift,
  input  logic                                      wr_last,
  input  logic [FEATURE_WIDTH-1:0]                  wr_data,
  output logic                                      rd_valid,
  input  logic                                      rd_ready,
  output logic [TN*KERNEL_SIZE*FEATURE_WIDTH-1:0]   data_out,
  output logic [TN-1:0]                             group_full,
  output logic                                      err_addr
);

  localparam int unsigned CNT_W = 2;

  logic [FEATURE_WIDTH-1:0] mem [2][TN][KERNEL_SIZE];
  logic [KERNEL_SIZE-1:0]   bitmap [TN];
  logic                     wr_bank;
  logic                     rd_bank;
  logic [CNT_W-1:0]         full_cnt;
  logic [CNT_W-1:0]         full_cnt_next;

  logic wr_fire;
  logic commit;
  logic rel_fire;
  logic addr_bad;

  assign wr_ready = (full_cnt != CNT_W'(2));
  assign rd_valid = (full_cnt != CNT_W'(0));
  assign wr_fire  = wr_valid && wr_ready;
  assign commit   = wr_fire && wr_last;
  assign rel_fire = rd_valid && rd_ready;
  assign addr_bad = (wr_mem_group >= GROUP_AW'(TN)) ||
                    (!wr_shift && (wr_mem_line >= LINE_AW'(KERNEL_SIZE)));

  // Occupancy: a commit and a release in the same cycle cancel out.
  always_comb begin
    full_cnt_next = full_cnt;
    case ({commit, rel_fire})
      2'b10:   full_cnt_next = full_cnt + CNT_W'(1);
      2'b01:   full_cnt_next = full_cnt - CNT_W'(1);
      default: full_cnt_next = full_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full_cnt <= '0;
      err_addr <= 1'b0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned g = 0; g < TN; g++)
          for (int unsigned l = 0; l < KERNEL_SIZE; l++)
            mem[b][g][l] <= '0;
      for (int unsigned g = 0; g < TN; g++)
        bitmap[g] <= '0;
    end else begin
      full_cnt <= full_cnt_next;
      if (wr_fire && addr_bad)
        err_addr <= 1'b1;
      for (int unsigned g = 0; g < TN; g++) begin
        if (wr_fire && !addr_bad && (wr_mem_group == GROUP_AW'(g))) begin
          if (wr_shift) begin
            // Line 0 is the oldest entry; new data enters at the top.
            for (int unsigned l = 0; l + 1 < KERNEL_SIZE; l++)
              mem[wr_bank][g][l] <= mem[wr_bank][g][l+1];
            mem[wr_bank][g][KERNEL_SIZE-1] <= wr_data;
            bitmap[g] <= {1'b1, bitmap[g][KERNEL_SIZE-1:1]};
          end else begin
            for (int unsigned l = 0; l < KERNEL_SIZE; l++) begin
              if (wr_mem_line == LINE_AW'(l)) begin
                mem[wr_bank][g][l] <= wr_data;
                bitmap[g][l]       <= 1'b1;
              end
            end
          end
        end
      end
      // Commit overrides the bitmap update of its own beat; storage keeps it.
      if (commit) begin
        wr_bank <= ~wr_bank;
        for (int unsigned g = 0; g < TN; g++)
          bitmap[g] <= '0;
      end
      if (rel_fire)
        rd_bank <= ~rd_bank;
    end
  end

  always_comb begin
    group_full = '0;
    for (int unsigned g = 0; g < TN; g++)
      group_full[g] = &bitmap[g];
  end

  always_comb begin
    data_out = '0;
    if (rd_valid)
      for (int unsigned g = 0; g < TN; g++)
        for (int unsigned l = 0; l < KERNEL_SIZE; l++)
          data_out[(g*KERNEL_SIZE+l)*FEATURE_WIDTH +: FEATURE_WIDTH] = mem[rd_bank][g][l];
  end

endmodule

// File: tb/tb_scratchpad_feature_pingpong.sv
// Directed bench for scratchpad_feature_pingpong: fill, backpressure, shift,
// address errors, simultaneous commit/release and mid-fill reset.
module tb_scratchpad_feature_pingpong;

  localparam int unsigned TN = 4;
  localparam int unsigned KS = 5;
  localparam int unsigned FW = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [8:0]            wr_mem_group;
  logic [3:0]            wr_mem_line;
  logic                  wr_shift;
  logic                  wr_last;
  logic [FW-1:0]         wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [TN*KS*FW-1:0]   data_out;
  logic [TN-1:0]         group_full;
  logic                  err_addr;

  int tests = 0;
  int fails = 0;

  scratchpad_feature_pingpong dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_mem_group(wr_mem_group), .wr_mem_line(wr_mem_line),
    .wr_shift(wr_shift), .wr_last(wr_last), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .data_out(data_out),
    .group_full(group_full), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] ent(int g, int l);
    return data_out[(g*KS+l)*FW +: FW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present one beat across the next posedge.
  task automatic beat(input int g, input int l, input logic sh, input logic last,
                      input logic [FW-1:0] d);
    wr_valid     = 1'b1;
    wr_mem_group = 9'(g);
    wr_mem_line  = 4'(l);
    wr_shift     = sh;
    wr_last      = last;
    wr_data      = d;
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_shift = 1'b0;
  endtask

  task automatic release_pulse();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string p);
    chk({p, "_wr_ready"},   64'(wr_ready), 64'd1);
    chk({p, "_rd_valid"},   64'(rd_valid), 64'd0);
    chk({p, "_dout_zero"},  64'(|data_out), 64'd0);
    chk({p, "_group_full"}, 64'(group_full), 64'd0);
    chk({p, "_err_addr"},   64'(err_addr), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_mem_group = '0; wr_mem_line = '0;
    wr_shift = 1'b0; wr_last = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk_reset_state("rst");

    // Random fill of bank 0 with (g*16+l)
    for (int g = 0; g < 4; g++) begin
      for (int l = 0; l < 5; l++) begin
        if (g == 3 && l == 4)
          chk("gf_before_last", 64'(group_full), 64'h7);
        beat(g, l, 1'b0, (g == 3 && l == 4), 16'(g*16 + l));
        if (g == 0 && l == 4)
          chk("gf_group0", 64'(group_full), 64'h1);
      end
    end
    chk("fill_rd_valid", 64'(rd_valid), 64'd1);
    chk("fill_e23", 64'(ent(2, 3)), 64'h0023);
    chk("fill_e00", 64'(ent(0, 0)), 64'h0000);
    chk("fill_e34", 64'(ent(3, 4)), 64'h0034);
    chk("fill_gf_clear", 64'(group_full), 64'h0);
    chk("fill_wr_ready", 64'(wr_ready), 64'd1);

    // Backpressure: second bank committed, nothing released
    beat(0, 0, 1'b0, 1'b1, 16'h1111);
    chk("bp_wr_ready_low", 64'(wr_ready), 64'd0);
    chk("bp_rd_valid", 64'(rd_valid), 64'd1);
    chk("bp_still_bank0", 64'(ent(2, 3)), 64'h0023);
    beat(1, 1, 1'b0, 1'b1, 16'hBEEF);
    chk("bp_hold_wr_ready", 64'(wr_ready), 64'd0);
    chk("bp_hold_gf", 64'(group_full), 64'h0);
    chk("bp_hold_e11", 64'(ent(1, 1)), 64'h0011);
    release_pulse();
    chk("bp_rel_wr_ready", 64'(wr_ready), 64'd1);
    chk("bp_rel_rd_valid", 64'(rd_valid), 64'd1);
    chk("bp_bank1_e00", 64'(ent(0, 0)), 64'h1111);
    chk("bp_bank1_e23", 64'(ent(2, 3)), 64'h0000);
    chk("bp_bank1_e11", 64'(ent(1, 1)), 64'h0000);

    // Shift mode into group 1 of bank 0; last beat commits while bank 1 releases
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) rd_ready = 1'b1;
      beat(1, 0, 1'b1, (i == 7), 16'(i));
      rd_ready = 1'b0;
      if (i == 4) chk("sh_gf_4beats", 64'(group_full), 64'h0);
      if (i == 5) chk("sh_gf_5beats", 64'(group_full), 64'h2);
    end
    chk("sim_rd_valid", 64'(rd_valid), 64'd1);
    chk("sim_wr_ready", 64'(wr_ready), 64'd1);
    for (int l = 0; l < 5; l++)
      chk($sformatf("sh_g1_l%0d", l), 64'(ent(1, l)), 64'(l + 3));
    chk("sim_bank0_e23", 64'(ent(2, 3)), 64'h0023);
    chk("sim_bank0_e00", 64'(ent(0, 0)), 64'h0000);

    // Address errors into bank 1
    beat(4, 0, 1'b0, 1'b0, 16'hFFFF);
    chk("err_grp", 64'(err_addr), 64'd1);
    chk("err_grp_gf", 64'(group_full), 64'h0);
    beat(0, 5, 1'b0, 1'b0, 16'hFFFF);
    chk("err_line", 64'(err_addr), 64'd1);
    beat(4, 0, 1'b0, 1'b1, 16'hFFFF);
    chk("err_commit_wr_ready", 64'(wr_ready), 64'd0);
    release_pulse();
    chk("err_bank1_e00", 64'(ent(0, 0)), 64'h1111);
    chk("err_bank1_e05", 64'(ent(0, 4)), 64'h0000);
    chk("err_sticky", 64'(err_addr), 64'd1);

    // Mid-fill reset
    release_pulse();
    beat(2, 0, 1'b0, 1'b0, 16'h00A0);
    beat(2, 1, 1'b0, 1'b0, 16'h00A1);
    beat(2, 2, 1'b0, 1'b0, 16'h00A2);
    do_reset();
    chk_reset_state("mid");
    beat(0, 0, 1'b0, 1'b1, 16'h0042);
    chk("post_rd_valid", 64'(rd_valid), 64'd1);
    chk("post_e00", 64'(ent(0, 0)), 64'h0042);
    chk("post_e23", 64'(ent(2, 3)), 64'h0000);
    chk("post_e21", 64'(ent(2, 1)), 64'h0000);
    chk("post_e14", 64'(ent(1, 4)), 64'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
